// File: rtl/peripheral_keypad.sv
// rtl/peripheral_keypad.sv - 4x4 matrix keypad scanner with debounce and keycode FIFO
module peripheral_keypad #(
  parameter int CLK_FREQ   = 12000000,
  parameter int SCAN_HZ    = 1000,
  parameter int DEB_SCANS  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_in,
  input  logic        cs,
  input  logic [4:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out,
  output logic [3:0]  col_out,
  input  logic [3:0]  row_in
);

  localparam int PERIOD_RAW = CLK_FREQ / SCAN_HZ;
  localparam int PERIOD     = (PERIOD_RAW < 2) ? 2 : PERIOD_RAW;
  localparam int TW         = $clog2(PERIOD);
  localparam int PW         = $clog2(FIFO_DEPTH);
  localparam int CW         = PW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_CAND, ST_HELD} state_t;

  logic [3:0]    row_s1_q, row_s2_q;
  logic [TW-1:0] tick_q;
  logic [1:0]    col_q;
  logic [15:0]   scan_q;
  logic [3:0]    col_out_q;
  logic          enable_q;
  logic          ovf_q;
  logic [31:0]   d_out_q;

  state_t        state_q;
  logic [3:0]    cand_q, cnt_q, rcnt_q;
  logic          push_q;
  logic [3:0]    push_code_q;

  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;

  logic [28:0]   unused_d_in;
  assign unused_d_in = d_in[31:3];

  logic sel_status, sel_data, sel_ctrl, bus_rd, ctrl_wr;
  logic enable_d, flush, ovf_clr, not_empty, full, pop, do_push;
  logic tick_last, scan_done, scan_single, scan_none;
  logic [1:0]  col_next;
  logic [15:0] scan_full;
  logic [3:0]  key_code;
  logic [31:0] rdata;

  assign sel_status = (addr == 5'h00);
  assign sel_data   = (addr == 5'h04);
  assign sel_ctrl   = (addr == 5'h08);
  assign bus_rd     = cs & rd;
  assign ctrl_wr    = cs & wr & sel_ctrl;
  assign enable_d   = ctrl_wr ? d_in[0] : enable_q;
  assign flush      = ctrl_wr & d_in[2];
  assign ovf_clr    = ctrl_wr & d_in[1];
  assign not_empty  = (count_q != '0);
  assign full       = (count_q == CW'(FIFO_DEPTH));
  assign pop        = bus_rd & sel_data & not_empty;
  assign do_push    = push_q & ~flush & (~full | pop);

  assign tick_last  = (tick_q == TW'(PERIOD - 1));
  assign col_next   = tick_last ? col_q + 2'd1 : col_q;
  assign scan_done  = tick_last & (col_q == 2'd3);

  // Intersections seen so far this scan, including the column sampled now.
  always_comb begin
    scan_full = scan_q;
    for (int r = 0; r < 4; r++)
      if (!row_s2_q[r]) scan_full[4*r + int'(col_q)] = 1'b1;
    key_code = 4'd0;
    for (int i = 0; i < 16; i++)
      if (scan_full[i]) key_code = 4'(i);
  end

  assign scan_single = $onehot(scan_full);
  assign scan_none   = (scan_full == 16'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
    end else begin
      row_s1_q <= row_in;
      row_s2_q <= row_s1_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q    <= '0;
      col_q     <= 2'd0;
      scan_q    <= 16'd0;
      col_out_q <= 4'b1111;
    end else if (!enable_d) begin
      tick_q    <= '0;
      col_q     <= 2'd0;
      scan_q    <= 16'd0;
      col_out_q <= 4'b1111;
    end else begin
      col_out_q <= ~(4'b0001 << col_next);
      if (tick_last) begin
        tick_q <= '0;
        col_q  <= col_q + 2'd1;
        scan_q <= (col_q == 2'd3) ? 16'd0 : scan_full;
      end else begin
        tick_q <= tick_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cand_q      <= 4'd0;
      cnt_q       <= 4'd0;
      rcnt_q      <= 4'd0;
      push_q      <= 1'b0;
      push_code_q <= 4'd0;
    end else begin
      push_q <= 1'b0;
      if (!enable_d) begin
        state_q <= ST_IDLE;
      end else if (scan_done) begin
        case (state_q)
          ST_IDLE: begin
            if (scan_single) begin
              cand_q <= key_code;
              cnt_q  <= 4'd1;
              if (DEB_SCANS <= 1) begin
                push_q      <= 1'b1;
                push_code_q <= key_code;
                rcnt_q      <= 4'd0;
                state_q     <= ST_HELD;
              end else begin
                state_q <= ST_CAND;
              end
            end
          end
          ST_CAND: begin
            if (scan_single && key_code == cand_q) begin
              if (int'(cnt_q) + 1 >= DEB_SCANS) begin
                push_q      <= 1'b1;
                push_code_q <= cand_q;
                rcnt_q      <= 4'd0;
                state_q     <= ST_HELD;
              end else begin
                cnt_q <= cnt_q + 4'd1;
              end
            end else if (scan_single) begin
              cand_q <= key_code;
              cnt_q  <= 4'd1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
          ST_HELD: begin
            if (!scan_none) begin
              rcnt_q <= 4'd0;
            end else if (int'(rcnt_q) + 1 >= DEB_SCANS) begin
              state_q <= ST_IDLE;
            end else begin
              rcnt_q <= rcnt_q + 4'd1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_code_q;
  end

  // Flush wins over a simultaneous push or pop; a drop while full is sticky.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      enable_q <= 1'b1;
    end else begin
      if (ctrl_wr) enable_q <= d_in[0];
      if (push_q && !flush && full && !pop) ovf_q <= 1'b1;
      else if (ovf_clr)                     ovf_q <= 1'b0;
      if (flush) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
      end else begin
        if (do_push) wptr_q <= wptr_q + PW'(1);
        if (pop)     rptr_q <= rptr_q + PW'(1);
        case ({do_push, pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (sel_status) begin
      rdata[0]   = not_empty;
      rdata[1]   = full;
      rdata[2]   = ovf_q;
      rdata[7:4] = 4'(count_q);
    end else if (sel_data) begin
      if (not_empty) begin
        rdata[3:0] = mem_q[rptr_q];
        rdata[8]   = 1'b1;
      end
    end else if (sel_ctrl) begin
      rdata[0] = enable_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       d_out_q <= 32'd0;
    else if (bus_rd) d_out_q <= rdata;
  end

  assign d_out   = d_out_q;
  assign col_out = col_out_q;

endmodule

// File: tb/tb_peripheral_keypad.sv
// tb/tb_peripheral_keypad.sv - self-checking bench for peripheral_keypad
module tb_peripheral_keypad;

  localparam int DEB   = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] d_in;
  logic        cs, rd, wr;
  logic [4:0]  addr;
  logic [31:0] d_out;
  logic [3:0]  col_out, row_in;

  logic [15:0] pressed, stim_pat, cur_pat;
  logic [3:0]  prev_col;
  bit          have_pat, armed, movf;
  int          scans_started;
  int          n_cmp, n_err;
  int          mq[$];
  int          hist[$];

  peripheral_keypad #(.CLK_FREQ(400), .SCAN_HZ(100), .DEB_SCANS(DEB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .d_in(d_in), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
    .d_out(d_out), .col_out(col_out), .row_in(row_in)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its row to its column while that column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) row_in[r] = ~|(pressed[r*4 +: 4] & ~col_out);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_push(input int k);
    if (mq.size() == DEPTH) movf = 1'b1;
    else mq.push_back(k);
  endfunction

  // A code is accepted when the last DEB scans saw only that key and the keypad
  // had been seen fully released (DEB empty scans) since the previous acceptance.
  function automatic void model_scan(input logic [15:0] p);
    int cls, a, b;
    if ($countones(p) == 0) cls = -1;
    else if ($countones(p) > 1) cls = -2;
    else begin
      cls = 0;
      for (int i = 0; i < 16; i++) if (p[i]) cls = i;
    end
    hist.push_back(cls);
    if (hist.size() >= DEB) begin
      a = hist[hist.size()-2];
      b = hist[hist.size()-1];
      if (armed && a >= 0 && a == b) begin
        model_push(b);
        armed = 1'b0;
      end else if (!armed && a == -1 && b == -1) begin
        armed = 1'b1;
      end
    end
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s = 32'd0;
    s[0] = (mq.size() != 0);
    s[1] = (mq.size() == DEPTH);
    s[2] = movf;
    s[7:4] = 4'(mq.size());
    return s;
  endfunction

  function automatic logic [31:0] m_data();
    logic [31:0] s = 32'd0;
    if (mq.size() != 0) begin
      s[8] = 1'b1;
      s[3:0] = 4'(mq[0]);
    end
    return s;
  endfunction

  function automatic void model_scan_reset();
    hist.delete();
    armed = 1'b1;
    have_pat = 1'b0;
  endfunction

  // Scan monitor: each column-0 start ends the previous scan and applies the next pattern.
  initial begin
    prev_col = 4'hF;
    forever begin
      @(negedge clk);
      if (col_out == 4'b1110 && prev_col != 4'b1110) begin
        if (have_pat) model_scan(cur_pat);
        pressed = stim_pat;
        cur_pat = stim_pat;
        have_pat = 1'b1;
        scans_started++;
      end
      prev_col = col_out;
    end
  end

  task automatic wait_scans(input int n);
    int target = scans_started + n;
    int guard = 0;
    while (scans_started < target && guard < 16*n + 80) begin
      @(negedge clk);
      guard++;
    end
    check("scan_progress", 32'(scans_started >= target), 32'd1);
  endtask

  task automatic hold(input logic [15:0] pat, input int n);
    stim_pat = pat;
    wait_scans(n);
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] data);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    data = d_out;
    if (a == 5'h04 && mq.size() != 0) void'(mq.pop_front());
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] v);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = v;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
    if (a == 5'h08) begin
      if (v[1]) movf = 1'b0;
      if (v[2]) mq.delete();
      if (!v[0]) model_scan_reset();
    end
  endtask

  task automatic rd_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] obs;
    bus_read(a, obs);
    check(tag, obs, exp);
  endtask

  task automatic rd_model(input string tag, input logic [4:0] a);
    logic [31:0] exp;
    exp = (a == 5'h04) ? m_data() : m_status();
    rd_check(tag, a, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] p;
    int k1, k2;
    n_cmp = 0; n_err = 0; scans_started = 0;
    reset = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 5'd0; d_in = 32'd0;
    pressed = 16'd0; stim_pat = 16'd0; cur_pat = 16'd0;
    movf = 1'b0; model_scan_reset();

    repeat (3) @(negedge clk);
    check("reset_col_out", 32'(col_out), 32'hF);
    check("reset_d_out", d_out, 32'd0);
    reset = 1'b0;
    rd_check("reset_status", 5'h00, 32'h000);
    rd_check("reset_ctrl", 5'h08, 32'h001);

    hold(16'h1 << 9, 5);
    hold(16'h0, 3);
    rd_check("single_status", 5'h00, 32'h011);
    rd_check("single_data", 5'h04, 32'h109);
    rd_check("single_status_after", 5'h00, 32'h000);
    rd_check("empty_data", 5'h04, 32'h000);

    hold(16'h1 << 5, 1); hold(16'h0, 1); hold(16'h1 << 5, 1); hold(16'h0, 3);
    rd_check("bounce_status", 5'h00, 32'h000);
    hold(16'h1 << 5, 2); hold(16'h0, 3);
    rd_check("bounce_data", 5'h04, 32'h105);

    foreach (mq[i]) ; // model already drained
    for (int i = 0; i < 6; i++) begin
      k1 = (i < 4) ? i + 1 : i + 2;
      hold(16'h1 << k1, 2);
      hold(16'h0, 2);
    end
    hold(16'h0, 1);
    rd_check("ovf_status", 5'h00, 32'h047);
    rd_check("ovf_data0", 5'h04, 32'h101);
    rd_check("ovf_data1", 5'h04, 32'h102);
    rd_check("ovf_data2", 5'h04, 32'h103);
    rd_check("ovf_data3", 5'h04, 32'h104);
    rd_check("ovf_data_empty", 5'h04, 32'h000);
    rd_check("ovf_sticky", 5'h00, 32'h004);
    bus_write(5'h08, 32'h3);
    rd_check("ovf_cleared", 5'h00, 32'h000);

    hold(16'h8001, 4);
    rd_check("multi_status", 5'h00, 32'h000);
    hold(16'h0001, 2); hold(16'h0, 3);
    rd_check("multi_release_data", 5'h04, 32'h100);

    hold(16'h1 << 3, 12); hold(16'h0, 1); hold(16'h1 << 10, 3); hold(16'h0, 2);
    rd_check("held_status", 5'h00, 32'h011);
    hold(16'h1 << 10, 2); hold(16'h0, 3);
    rd_check("held_data0", 5'h04, 32'h103);
    rd_check("held_data1", 5'h04, 32'h10A);

    hold(16'h1 << 12, 3);
    stim_pat = 16'h0;
    repeat (6) @(negedge clk);
    bus_write(5'h08, 32'h0);
    check("disable_col_out", 32'(col_out), 32'hF);
    rd_check("disable_ctrl", 5'h08, 32'h000);
    repeat (20) @(negedge clk);
    check("disable_col_idle", 32'(col_out), 32'hF);
    rd_check("disable_data", 5'h04, 32'h10C);
    bus_write(5'h08, 32'h1);

    hold(16'h1 << 8, 2); hold(16'h0, 3);
    rd_check("pre_reset_status", 5'h00, 32'h011);
    hold(16'h1 << 7, 2);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_reset_col_out", 32'(col_out), 32'hF);
    check("async_reset_d_out", d_out, 32'd0);
    mq.delete(); movf = 1'b0; stim_pat = 16'h0; model_scan_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    rd_check("post_reset_status", 5'h00, 32'h000);
    rd_check("post_reset_ctrl", 5'h08, 32'h001);

    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 4))
        0, 1: hold(16'h1 << $urandom_range(0, 15), $urandom_range(1, 4));
        2: begin
          k1 = $urandom_range(0, 15);
          k2 = (k1 + $urandom_range(1, 15)) % 16;
          p = (16'h1 << k1) | (16'h1 << k2);
          hold(p, $urandom_range(1, 2));
        end
        3: hold(16'h0, $urandom_range(1, 3));
        default: begin
          hold(16'h0, 2);
          repeat ($urandom_range(1, 3))
            rd_model("rand_read", ($urandom_range(0, 1) == 0) ? 5'h00 : 5'h04);
          if ($urandom_range(0, 3) == 0) bus_write(5'h08, 32'h3);
        end
      endcase
    end
    hold(16'h0, 3);
    rd_model("final_status", 5'h00);
    for (int i = 0; i < DEPTH + 1; i++) rd_model("final_data", 5'h04);
    rd_model("final_status_empty", 5'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
